// File: rtl/xadac_pkg.sv
// Shared types for the xadac channel pipeline stages.
// Holds the spill-stage state encoding, stats width and the occupancy decode helper.
package xadac_pkg;

    typedef enum logic [1:0] {
        SPILL_EMPTY,
        SPILL_HALF,
        SPILL_FULL
    } spill_state_e;

    localparam int SpillStatsW = 32;

    function automatic logic [1:0] spill_occupancy(spill_state_e s);
        case (s)
            SPILL_HALF: return 2'd1;
            SPILL_FULL: return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/xadac_spill.sv
// Two-entry fully registered valid/ready stage: mst_valid, mst_data and slv_ready all come from flops.
// Optional stall counter port stall_cnt is enabled by defining XADAC_SPILL_STATS_EN.
module xadac_spill
    import xadac_pkg::*;
#(
    parameter int  Passthrough = 0,
    parameter type DataT       = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  DataT       slv_data,
    input  logic       slv_valid,
    output logic       slv_ready,
    output DataT       mst_data,
    output logic       mst_valid,
    input  logic       mst_ready,
    output logic [1:0] occupancy
`ifdef XADAC_SPILL_STATS_EN
    ,
    output logic [SpillStatsW-1:0] stall_cnt
`endif
);

    if (Passthrough != 0) begin : g_pass
        assign mst_data  = slv_data;
        assign mst_valid = slv_valid;
        assign slv_ready = mst_ready;
        assign occupancy = 2'd0;
    end else begin : g_spill
        spill_state_e state_q, state_d;
        DataT         a_q, a_d;
        DataT         b_q, b_d;
        logic         slv_ready_q;
        logic         mst_valid_q;
        logic [1:0]   occ_q;
        logic         in_hs;
        logic         out_hs;

        assign in_hs  = slv_valid && slv_ready_q;
        assign out_hs = mst_valid_q && mst_ready;

        // Slot A always feeds the output; slot B only fills when A is stuck.
        always_comb begin
            state_d = state_q;
            a_d     = a_q;
            b_d     = b_q;
            unique case (state_q)
                SPILL_EMPTY: begin
                    if (in_hs) begin
                        state_d = SPILL_HALF;
                        a_d     = slv_data;
                    end
                end
                SPILL_HALF: begin
                    if (in_hs && out_hs) begin
                        a_d = slv_data;
                    end else if (in_hs) begin
                        state_d = SPILL_FULL;
                        b_d     = slv_data;
                    end else if (out_hs) begin
                        state_d = SPILL_EMPTY;
                    end
                end
                SPILL_FULL: begin
                    if (out_hs) begin
                        state_d = SPILL_HALF;
                        a_d     = b_q;
                    end
                end
                default: begin
                    state_d = SPILL_EMPTY;
                end
            endcase
            if (flush) begin
                state_d = SPILL_EMPTY;
            end
        end

        // Status outputs are registered from the next state so nothing combinational leaves the stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= SPILL_EMPTY;
                a_q         <= '0;
                b_q         <= '0;
                slv_ready_q <= 1'b0;
                mst_valid_q <= 1'b0;
                occ_q       <= 2'd0;
            end else begin
                state_q     <= state_d;
                a_q         <= a_d;
                b_q         <= b_d;
                slv_ready_q <= (state_d != SPILL_FULL);
                mst_valid_q <= (state_d != SPILL_EMPTY);
                occ_q       <= spill_occupancy(state_d);
            end
        end

        assign mst_data  = a_q;
        assign mst_valid = mst_valid_q;
        assign slv_ready = slv_ready_q;
        assign occupancy = occ_q;
    end

`ifdef XADAC_SPILL_STATS_EN
    if (SpillStatsW > 0) begin : g_stats
        logic [SpillStatsW-1:0] stall_q;

        // Saturating count of cycles where the downstream consumer stalls a valid beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                stall_q <= '0;
            end else if (mst_valid && !mst_ready && (stall_q != '1)) begin
                stall_q <= stall_q + SpillStatsW'(1);
            end
        end

        assign stall_cnt = stall_q;
    end
`endif

endmodule

// File: tb/tb_xadac_spill.sv
// Scoreboard bench for xadac_spill: registered instance plus a Passthrough=1 instance.
// Stall counter checks compile in when XADAC_SPILL_STATS_EN is defined.
module tb_xadac_spill;
    import xadac_pkg::*;

    typedef logic [7:0] data_t;

    logic       clk;
    logic       rst;
    logic       flush;
    data_t      slv_data;
    logic       slv_valid;
    logic       slv_ready;
    data_t      mst_data;
    logic       mst_valid;
    logic       mst_ready;
    logic [1:0] occupancy;

    data_t      pt_slv_data;
    logic       pt_slv_valid;
    logic       pt_slv_ready;
    data_t      pt_mst_data;
    logic       pt_mst_valid;
    logic       pt_mst_ready;
    logic [1:0] pt_occupancy;

`ifdef XADAC_SPILL_STATS_EN
    logic [SpillStatsW-1:0] stall_cnt;
    logic [SpillStatsW-1:0] pt_stall_cnt;
`endif

    int    checks   = 0;
    int    failures = 0;
    data_t sb_q[$];
    data_t sb_exp;

    xadac_spill #(.Passthrough(0), .DataT(data_t)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .slv_data(slv_data), .slv_valid(slv_valid), .slv_ready(slv_ready),
        .mst_data(mst_data), .mst_valid(mst_valid), .mst_ready(mst_ready),
        .occupancy(occupancy)
`ifdef XADAC_SPILL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    xadac_spill #(.Passthrough(1), .DataT(data_t)) dut_pt (
        .clk(clk), .rst(rst), .flush(flush),
        .slv_data(pt_slv_data), .slv_valid(pt_slv_valid), .slv_ready(pt_slv_ready),
        .mst_data(pt_mst_data), .mst_valid(pt_mst_valid), .mst_ready(pt_mst_ready),
        .occupancy(pt_occupancy)
`ifdef XADAC_SPILL_STATS_EN
        , .stall_cnt(pt_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track accepted beats and pop them as the stage hands them downstream.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (mst_valid && mst_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sb_order: got %h, required no beat (scoreboard empty)", mst_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (mst_data !== sb_exp) begin
                        failures++;
                        $display("[TB] FAIL sb_order: got %h, required %h", mst_data, sb_exp);
                    end
                end
            end
            if (slv_valid && slv_ready) sb_q.push_back(slv_data);
            if (flush) sb_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (slv_ready !== 1'b0 || mst_valid !== 1'b0 || occupancy !== 2'd0 || mst_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b occ=%0d data=%h, required 0 0 0 00",
                     slv_ready, mst_valid, occupancy, mst_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (slv_ready !== 1'b1 || mst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b, required 1 0", slv_ready, mst_valid);
        end
    endtask

    task automatic test_stream();
        mst_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            slv_valid = 1'b1;
            slv_data  = 8'(i);
            @(negedge clk);
            if (i > 1) begin
                checks++;
                if (mst_data !== 8'(i - 1) || mst_valid !== 1'b1 || occupancy !== 2'd1 || slv_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stream_beat: got data=%h vld=%b occ=%0d rdy=%b, required %h 1 1 1",
                             mst_data, mst_valid, occupancy, slv_ready, 8'(i - 1));
                end
            end
        end
        tick();
        slv_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd0 || mst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_drain: got occ=%0d vld=%b, required 0 0", occupancy, mst_valid);
        end
    endtask

    task automatic test_backpressure();
        tick();
        mst_ready = 1'b0;
        slv_valid = 1'b1;
        slv_data  = 8'h0A;
        tick();
        slv_data  = 8'h0B;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd1 || mst_data !== 8'h0A || slv_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_half: got occ=%0d data=%h rdy=%b, required 1 0a 1", occupancy, mst_data, slv_ready);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            slv_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (occupancy !== 2'd2 || slv_ready !== 1'b0 || mst_data !== 8'h0A || mst_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bp_full: got occ=%0d rdy=%b data=%h vld=%b, required 2 0 0a 1",
                         occupancy, slv_ready, mst_data, mst_valid);
            end
        end
        tick();
        mst_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd1 || slv_ready !== 1'b1 || mst_data !== 8'h0B) begin
            failures++;
            $display("[TB] FAIL bp_drain: got occ=%0d rdy=%b data=%h, required 1 1 0b", occupancy, slv_ready, mst_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd0 || mst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_empty: got occ=%0d vld=%b, required 0 0", occupancy, mst_valid);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        mst_ready = 1'b1;
        slv_valid = 1'b1;
        slv_data  = 8'h05;
        tick();
        slv_data  = 8'h06;
        tick();
        slv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mst_data !== 8'h06 || occupancy !== 2'd1 || mst_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_swap: got data=%h occ=%0d vld=%b, required 06 1 1", mst_data, occupancy, mst_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        tick();
        mst_ready = 1'b0;
        slv_valid = 1'b1;
        slv_data  = 8'h11;
        tick();
        slv_data  = 8'h12;
        tick();
        slv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("[TB] FAIL flush_setup: got occ=%0d, required 2", occupancy);
        end
        tick();
        flush     = 1'b1;
        slv_valid = 1'b1;
        slv_data  = 8'h13;
        mst_ready = 1'b1;
        tick();
        flush     = 1'b0;
        slv_data  = 8'h07;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd0 || mst_valid !== 1'b0 || slv_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_empty: got occ=%0d vld=%b rdy=%b, required 0 0 1", occupancy, mst_valid, slv_ready);
        end
        tick();
        slv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mst_data !== 8'h07 || mst_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_next: got data=%h vld=%b, required 07 1", mst_data, mst_valid);
        end
        tick();
    endtask

    task automatic test_rst_full();
        tick();
        mst_ready = 1'b0;
        slv_valid = 1'b1;
        slv_data  = 8'h21;
        tick();
        slv_data  = 8'h22;
        tick();
        slv_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        mst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mst_valid !== 1'b0 || slv_ready !== 1'b0 || occupancy !== 2'd0 || mst_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_full: got vld=%b rdy=%b occ=%0d data=%h, required 0 0 0 00",
                     mst_valid, slv_ready, occupancy, mst_data);
        end
        tick();
        slv_valid = 1'b1;
        slv_data  = 8'h30;
        @(negedge clk);
        checks++;
        if (slv_ready !== 1'b1 || mst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_recover: got rdy=%b vld=%b, required 1 0", slv_ready, mst_valid);
        end
        tick();
        slv_data  = 8'h31;
        tick();
        slv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mst_data !== 8'h31 || occupancy !== 2'd1) begin
            failures++;
            $display("[TB] FAIL rst_stream: got data=%h occ=%0d, required 31 1", mst_data, occupancy);
        end
        tick();
    endtask

`ifdef XADAC_SPILL_STATS_EN
    task automatic test_stats();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mst_ready = 1'b0;
        tick();
        slv_valid = 1'b1;
        slv_data  = 8'h40;
        tick();
        slv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL stats_start: got %0d, required 0", stall_cnt);
        end
        for (int k = 0; k < 10; k++) tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd10) begin
            failures++;
            $display("[TB] FAIL stats_count: got %0d, required 10", stall_cnt);
        end
        flush     = 1'b1;
        mst_ready = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd10) begin
            failures++;
            $display("[TB] FAIL stats_flush: got %0d, required 10", stall_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL stats_rst: got %0d, required 0", stall_cnt);
        end
        tick();
    endtask
`endif

    task automatic test_passthrough();
        data_t d;
        logic  v;
        logic  r;
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            pt_slv_data  = d;
            pt_slv_valid = v;
            pt_mst_ready = r;
            #1;
            checks++;
            if (pt_mst_data !== d || pt_mst_valid !== v || pt_slv_ready !== r) begin
                failures++;
                $display("[TB] FAIL passthrough: got data=%h vld=%b rdy=%b, required %h %b %b",
                         pt_mst_data, pt_mst_valid, pt_slv_ready, d, v, r);
            end
            tick();
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        slv_data     = '0;
        slv_valid    = 1'b0;
        mst_ready    = 1'b0;
        pt_slv_data  = '0;
        pt_slv_valid = 1'b0;
        pt_mst_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_full();
`ifdef XADAC_SPILL_STATS_EN
        test_stats();
`endif
        test_passthrough();

        tick();
        tick();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_leftover: got %0d beats still expected, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xadac_spill.md
Name: xadac_spill

Overview:
- Two-entry, fully registered valid/ready pipeline stage for xadac request/response channels.
- Registers the forward path (mst_valid, mst_data) and the backward path (slv_ready), so no combinational path crosses the stage in either direction.
- Complements the ready-registering skid stage: it is placed at the producer end of long channels, e.g. the accelerator response path back toward the core.
- Sustains one beat per cycle.

Parameters:
- Passthrough, 0, when 1: mst_data=slv_data, mst_valid=slv_valid, slv_ready=mst_ready, no state, flush ignored.
- DataT, logic, payload type; any packed type.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of all held beats
- slv_data  in  DataT  upstream payload
- slv_valid  in  1  upstream valid
- slv_ready  out  1  upstream ready; flop output
- mst_data  out  DataT  downstream payload; flop output
- mst_valid  out  1  downstream valid; flop output
- mst_ready  in  1  downstream ready
- occupancy  out  2  held beats, 0..2; flop output

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: slot A is the output register and drives mst_data/mst_valid. Slot B is the spill register.
- State encoding: EMPTY (no valid slot), HALF (A valid), FULL (A and B valid). occupancy = 0/1/2.
- Handshakes: in = slv_valid && slv_ready; out = mst_valid && mst_ready, both sampled at the clk edge.
- Transitions:
  - EMPTY, in -> HALF, A <= slv_data.
  - HALF, in && !out -> FULL, B <= slv_data.
  - HALF, in && out -> HALF, A <= slv_data.
  - HALF, !in && out -> EMPTY.
  - FULL, out -> HALF, A <= B. No in is possible in FULL.
  - All other cases: hold.
- slv_ready next value = (next state != FULL).
- Latency: first beat appears on mst_valid 1 cycle after its input handshake. Full throughput whenever mst_ready is held high.
- Ordering: strict FIFO. A beat is never duplicated or dropped, except on flush.
- mst_valid, once high, stays high with stable mst_data until out.
- mst_data when mst_valid=0: holds its last value. Benches must not check it.
- Flush:
  - Next state EMPTY regardless of in/out in the same cycle.
  - A beat handshaken on either side in the flush cycle counts as transferred/consumed, then is discarded.
  - slv_ready is 1 in the cycle after flush.
- rst: next cycle slv_ready=0, mst_valid=0, mst_data='0, occupancy=0, all slots '0.
  - First cycle after rst deasserts: slv_ready rises to 1.
  - rst mid-transfer drops held beats silently. rst has priority over flush.

Optional Feature:
- Macro: XADAC_SPILL_STATS_EN.
- When defined, adds port stall_cnt (out, 32 bits), which counts cycles with mst_valid && !mst_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst. Not cleared by flush.
- When undefined, the port and counter are absent and the data path is identical.

Decomposition:
- Package xadac_pkg:
  - typedef enum logic [1:0] {SPILL_EMPTY, SPILL_HALF, SPILL_FULL} spill_state_e
  - localparam SpillStatsW = 32
- No sub-module. The optional stall counter is an in-module generate block under the macro.

Test Plan:
- Reset then steady stream: slv_valid=1 with data 1,2,3..., mst_ready=1 -> slv_ready=1 from the first post-reset cycle; mst sees 1,2,3... each one cycle later, one per cycle, occupancy=1.
- Backpressure: send 0xA, 0xB with mst_ready=0 -> occupancy 2, slv_ready=0 the cycle after the second accept, mst_data holds 0xA. Raise mst_ready -> 0xA then 0xB; slv_ready returns to 1 after the first drain.
- Simultaneous in/out in HALF: A=0x5, send 0x6 while mst_ready=1 -> next cycle mst_data=0x6, occupancy stays 1.
- Flush in FULL while in and out both asserted -> next cycle occupancy=0, mst_valid=0, slv_ready=1; the following beat 0x7 emerges first.
- rst asserted in FULL -> next cycle mst_valid=0, slv_ready=0, occupancy=0; after release, normal operation with no stale beats.
- Stats (macro defined): hold mst_valid high with mst_ready=0 for 10 cycles -> stall_cnt=10. Flush -> unchanged. rst -> 0.
- Passthrough=1: random valid/ready -> outputs equal inputs in the same cycle.
